if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the LC-3 pipeline; it is the producer that feeds the decode stage's instruction and next-PC inputs. It owns the PC and issues one-word reads to instruction memory over a req/rdy handshake. It honours pause, irq and branch/jump redirects (target plus condition from decode), and inserts NOP bubbles (16'h0000, BR with nzp=000) whenever no valid instruction is available. Registers update on posedge clk, so decode samples stable values at the following negedge.

## Interface
- PC_RESET, 16'h3000: PC value loaded on reset.
- TIMEOUT, 15: memory wait cycles before a fetch fault (used only with IF_TIMEOUT_EN; range 1-15).
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  active-low asynchronous reset.
- pause  in  1  pipeline stall; hold presented instruction.
- irq  in  1  interrupt entry in progress; suspend fetch.
- ifCond  in  1  redirect request (decode's jump/JSR condition).
- ifPCin  in  16  redirect target.
- ifMemReq  out  1  read request; combinational, = (state==S_REQ) && !irq.
- ifMemAddr  out  16  read address; = PC.
- ifMemRdy  in  1  read data valid this cycle; meaningful only while ifMemReq=1.
- ifMemData  in  16  instruction word.
- ifIRout  out  16  instruction to decode.
- ifNPCout  out  16  address of presented instruction + 1.

## Operation
- State: PC[15:0], buf[15:0], state in {S_IDLE, S_REQ, S_HOLD}; optional 4-bit wait counter.
- Reset (reset=0, async): state=S_IDLE, PC=PC_RESET, buf=0, ifIRout=16'h0000, ifNPCout=PC_RESET, counter=0. ifMemReq=0.
- S_IDLE: unconditional next state S_REQ; ifIRout=0000.
- Per-edge priority: ifCond > irq > pause > normal.
- ifCond=1 (any state): PC<=ifPCin, ifIRout<=0000, ifNPCout unchanged, state<=S_REQ, counter<=0. Same-cycle ifMemRdy data is discarded. The request may be abandoned mid-wait; the address changes the next cycle.
- irq=1 (ifCond=0): PC frozen, ifIRout<=0000, ifMemRdy ignored (ifMemReq is 0), state unchanged, counter<=0.
- S_REQ, rdy=1, pause=0: ifIRout<=ifMemData, ifNPCout<=PC+1, PC<=PC+1, stay in S_REQ.
- S_REQ, rdy=1, pause=1: buf<=ifMemData, PC unchanged, outputs held, state<=S_HOLD.
- S_REQ, rdy=0, pause=0: ifIRout<=0000 (bubble), ifNPCout held, ifMemReq stays high, address stable.
- S_REQ, rdy=0, pause=1: outputs held.
- S_HOLD: ifMemReq=0. While pause=1, hold. When pause=0: ifIRout<=buf, ifNPCout<=PC+1, PC<=PC+1, state<=S_REQ.
- PC+1 wraps 16'hFFFF to 16'h0000 with no flag.

## Timing
- Fetch latency: ifMemRdy sampled at posedge k puts the word on ifIRout after edge k. Decode captures it at negedge k+0.5.
- Throughput: 1 instruction/cycle while ifMemRdy is held high and pause=0.
- Pause with a fetched word: 1-entry hold in buf. No word is lost and none is duplicated.
- Redirect penalty: the first bubble appears after the redirect edge. The target word is presented no earlier than the following edge with rdy.
- ifMemReq/ifMemAddr are combinational from registered state and irq. They carry no path from ifMemRdy.
- Reset mid-wait: the request drops immediately (async). The fetch restarts at PC_RESET one cycle after S_IDLE.

## Configuration
- IF_TIMEOUT_EN defined:
  - Counter increments each S_REQ cycle with ifMemReq=1, rdy=0, pause=0.
  - On reaching TIMEOUT: ifIRout<=16'hD000 (EXC opcode), ifNPCout<=PC, PC unchanged, counter<=0, fetch retries.
  - Counter clears on rdy, ifCond, irq, reset.
- IF_TIMEOUT_EN undefined: no counter. The stage waits indefinitely for ifMemRdy.

## Test plan
- Reset release, rdy tied 1, memory[3000..3002]=1021,5262,0E02: ifIRout sequence 0000 (S_IDLE), then 1021/NPC 3001, 5262/NPC 3002, 0E02/NPC 3003, one per cycle.
- pause=1 for 3 cycles on the cycle rdy returns 1234 at PC 3005: outputs hold the prior instruction, ifMemReq=0 in S_HOLD. On release, 1234/NPC 3006 is presented exactly once.
- ifCond=1, ifPCin=4000 while rdy=1 returns AAAA: AAAA is never presented, ifIRout=0000, next ifMemAddr=4000.
- irq=1 for 2 cycles with rdy=1: ifMemReq=0, PC frozen, ifIRout=0000. Fetch resumes at the same PC.
- PC=FFFF, rdy=1, word 1111: ifNPCout=0000, next ifMemAddr=0000.
- IF_TIMEOUT_EN, TIMEOUT=15, rdy held 0 at PC 3010: 14 bubbles, then ifIRout=D000, ifNPCout=3010. Setting rdy=1 then presents the real word.

Source files
------------

// File: rtl/if_fetch.sv
// LC-3 instruction-fetch stage: owns the PC, fetches over req/rdy.
// Optional fetch timeout enabled by defining IF_TIMEOUT_EN.
module if_fetch #(
    parameter logic [15:0] PC_RESET = 16'h3000
`ifdef IF_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic        irq,
    input  logic        ifCond,
    input  logic [15:0] ifPCin,
    output logic        ifMemReq,
    output logic [15:0] ifMemAddr,
    input  logic        ifMemRdy,
    input  logic [15:0] ifMemData,
    output logic [15:0] ifIRout,
    output logic [15:0] ifNPCout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] NOP = 16'h0000;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] pc_inc;

`ifdef IF_TIMEOUT_EN
    localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    assign cnt_inc = cnt_q + 4'd1;

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign pc_inc    = pc_q + 16'd1;
    assign ifMemReq  = (state_q == S_REQ) && !irq;
    assign ifMemAddr = pc_q;
    assign ifIRout   = ir_q;
    assign ifNPCout  = npc_q;

    // Stage state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            buf_q   <= 16'h0000;
            ir_q    <= NOP;
            npc_q   <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
        end
    end

    // Next state: redirect beats irq beats pause beats normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        ir_d    = ir_q;
        npc_d   = npc_q;
`ifdef IF_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (ifCond) begin
            pc_d    = ifPCin;
            ir_d    = NOP;
            state_d = S_REQ;
`ifdef IF_TIMEOUT_EN
            cnt_d   = 4'd0;
`endif
        end else if (irq) begin
            ir_d    = NOP;
`ifdef IF_TIMEOUT_EN
            cnt_d   = 4'd0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ir_d    = NOP;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (ifMemRdy) begin
`ifdef IF_TIMEOUT_EN
                        cnt_d = 4'd0;
`endif
                        if (pause) begin
                            buf_d   = ifMemData;
                            state_d = S_HOLD;
                        end else begin
                            ir_d  = ifMemData;
                            npc_d = pc_inc;
                            pc_d  = pc_inc;
                        end
                    end else if (!pause) begin
`ifdef IF_TIMEOUT_EN
                        if (cnt_inc == TO_LIMIT) begin
                            ir_d  = 16'hD000;
                            npc_d = pc_q;
                            cnt_d = 4'd0;
                        end else begin
                            ir_d  = NOP;
                            cnt_d = cnt_inc;
                        end
`else
                        ir_d = NOP;
`endif
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        ir_d    = buf_q;
                        npc_d   = pc_inc;
                        pc_d    = pc_inc;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for the LC-3 fetch stage.
// Checks reset, streaming, pause hold, redirect, irq, wrap, stall/timeout.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pause;
    logic        irq;
    logic        ifCond;
    logic [15:0] ifPCin;
    logic        ifMemReq;
    logic [15:0] ifMemAddr;
    logic        ifMemRdy;
    logic [15:0] ifMemData;
    logic [15:0] ifIRout;
    logic [15:0] ifNPCout;

    logic [15:0] mem [0:65535];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ifMemData = mem[ifMemAddr];

    if_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .irq       (irq),
        .ifCond    (ifCond),
        .ifPCin    (ifPCin),
        .ifMemReq  (ifMemReq),
        .ifMemAddr (ifMemAddr),
        .ifMemRdy  (ifMemRdy),
        .ifMemData (ifMemData),
        .ifIRout   (ifIRout),
        .ifNPCout  (ifNPCout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pause = 1'b0; irq = 1'b0; ifCond = 1'b0;
        ifPCin = 16'h0000; ifMemRdy = 1'b1;
        step(); step();
        n_tests++;
        if ({ifMemReq, ifMemAddr, ifIRout, ifNPCout} !==
            {1'b0, 16'h3000, 16'h0000, 16'h3000}) begin
            n_fail++;
            $display("FAIL reset: req=%b addr=%h ir=%h npc=%h, need 0 3000 0000 3000",
                     ifMemReq, ifMemAddr, ifIRout, ifNPCout);
        end
    endtask

    task automatic test_fetch();
        logic [15:0] exp_ir [3];
        exp_ir[0] = 16'h1021; exp_ir[1] = 16'h5262; exp_ir[2] = 16'h0E02;
        reset = 1'b1;
        step();
        n_tests++;
        if ({ifMemReq, ifMemAddr, ifIRout} !== {1'b1, 16'h3000, 16'h0000}) begin
            n_fail++;
            $display("FAIL idle: req=%b addr=%h ir=%h, need 1 3000 0000",
                     ifMemReq, ifMemAddr, ifIRout);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({ifIRout, ifNPCout} !== {exp_ir[i], 16'h3001 + 16'(i)}) begin
                n_fail++;
                $display("FAIL fetch%0d: ir=%h npc=%h, need %h %h", i,
                         ifIRout, ifNPCout, exp_ir[i], 16'h3001 + 16'(i));
            end
        end
    endtask

    task automatic test_pause();
        step();
        step();
        n_tests++;
        if ({ifIRout, ifNPCout, ifMemAddr} !== {16'h4444, 16'h3005, 16'h3005}) begin
            n_fail++;
            $display("FAIL prepause: ir=%h npc=%h addr=%h, need 4444 3005 3005",
                     ifIRout, ifNPCout, ifMemAddr);
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({ifMemReq, ifIRout, ifNPCout} !== {1'b0, 16'h4444, 16'h3005}) begin
                n_fail++;
                $display("FAIL hold%0d: req=%b ir=%h npc=%h, need 0 4444 3005",
                         i, ifMemReq, ifIRout, ifNPCout);
            end
        end
        pause = 1'b0;
        step();
        n_tests++;
        if ({ifIRout, ifNPCout, ifMemReq, ifMemAddr} !==
            {16'h1234, 16'h3006, 1'b1, 16'h3006}) begin
            n_fail++;
            $display("FAIL release: ir=%h npc=%h req=%b addr=%h, need 1234 3006 1 3006",
                     ifIRout, ifNPCout, ifMemReq, ifMemAddr);
        end
        step();
        n_tests++;
        if ({ifIRout, ifNPCout} !== {16'h6666, 16'h3007}) begin
            n_fail++;
            $display("FAIL postpause: ir=%h npc=%h, need 6666 3007",
                     ifIRout, ifNPCout);
        end
    endtask

    task automatic test_redirect();
        ifCond = 1'b1; ifPCin = 16'h4000;
        step();
        ifCond = 1'b0;
        n_tests++;
        if ({ifIRout, ifNPCout, ifMemAddr} !== {16'h0000, 16'h3007, 16'h4000}) begin
            n_fail++;
            $display("FAIL redirect: ir=%h npc=%h addr=%h, need 0000 3007 4000",
                     ifIRout, ifNPCout, ifMemAddr);
        end
        step();
        n_tests++;
        if ({ifIRout, ifNPCout} !== {16'hBEEF, 16'h4001}) begin
            n_fail++;
            $display("FAIL target: ir=%h npc=%h, need beef 4001",
                     ifIRout, ifNPCout);
        end
    endtask

    task automatic test_irq();
        irq = 1'b1;
        #1;
        n_tests++;
        if (ifMemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_req_comb: req=%b, need 0", ifMemReq);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({ifMemReq, ifMemAddr, ifIRout, ifNPCout} !==
                {1'b0, 16'h4001, 16'h0000, 16'h4001}) begin
                n_fail++;
                $display("FAIL irq%0d: req=%b addr=%h ir=%h npc=%h, need 0 4001 0000 4001",
                         i, ifMemReq, ifMemAddr, ifIRout, ifNPCout);
            end
        end
        irq = 1'b0;
        step();
        n_tests++;
        if ({ifIRout, ifNPCout} !== {16'h7777, 16'h4002}) begin
            n_fail++;
            $display("FAIL irq_resume: ir=%h npc=%h, need 7777 4002",
                     ifIRout, ifNPCout);
        end
    endtask

    task automatic test_wrap();
        ifCond = 1'b1; ifPCin = 16'hFFFF;
        step();
        ifCond = 1'b0;
        step();
        n_tests++;
        if ({ifIRout, ifNPCout, ifMemAddr} !== {16'h1111, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap: ir=%h npc=%h addr=%h, need 1111 0000 0000",
                     ifIRout, ifNPCout, ifMemAddr);
        end
    endtask

    task automatic test_stall();
        ifCond = 1'b1; ifPCin = 16'h3010;
        step();
        ifCond = 1'b0;
        ifMemRdy = 1'b0;
`ifdef IF_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            step();
            n_tests++;
            if ({ifIRout, ifMemReq, ifMemAddr} !== {16'h0000, 1'b1, 16'h3010}) begin
                n_fail++;
                $display("FAIL bubble%0d: ir=%h req=%b addr=%h, need 0000 1 3010",
                         i, ifIRout, ifMemReq, ifMemAddr);
            end
        end
        step();
        n_tests++;
        if ({ifIRout, ifNPCout, ifMemAddr} !== {16'hD000, 16'h3010, 16'h3010}) begin
            n_fail++;
            $display("FAIL timeout: ir=%h npc=%h addr=%h, need d000 3010 3010",
                     ifIRout, ifNPCout, ifMemAddr);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if ({ifIRout, ifNPCout, ifMemReq, ifMemAddr} !==
                {16'h0000, 16'h0000, 1'b1, 16'h3010}) begin
                n_fail++;
                $display("FAIL wait%0d: ir=%h npc=%h req=%b addr=%h, need 0000 0000 1 3010",
                         i, ifIRout, ifNPCout, ifMemReq, ifMemAddr);
            end
        end
`endif
        ifMemRdy = 1'b1;
        step();
        n_tests++;
        if ({ifIRout, ifNPCout} !== {16'h2468, 16'h3011}) begin
            n_fail++;
            $display("FAIL stall_done: ir=%h npc=%h, need 2468 3011",
                     ifIRout, ifNPCout);
        end
    endtask

    task automatic test_reset_midwait();
        ifMemRdy = 1'b0;
        step();
        reset = 1'b0;
        #1;
        n_tests++;
        if ({ifMemReq, ifMemAddr, ifIRout, ifNPCout} !==
            {1'b0, 16'h3000, 16'h0000, 16'h3000}) begin
            n_fail++;
            $display("FAIL async_reset: req=%b addr=%h ir=%h npc=%h, need 0 3000 0000 3000",
                     ifMemReq, ifMemAddr, ifIRout, ifNPCout);
        end
        step();
        reset = 1'b1;
        ifMemRdy = 1'b1;
        step();
        step();
        n_tests++;
        if ({ifIRout, ifNPCout} !== {16'h1021, 16'h3001}) begin
            n_fail++;
            $display("FAIL restart: ir=%h npc=%h, need 1021 3001",
                     ifIRout, ifNPCout);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        mem[16'h3000] = 16'h1021;
        mem[16'h3001] = 16'h5262;
        mem[16'h3002] = 16'h0E02;
        mem[16'h3003] = 16'h3333;
        mem[16'h3004] = 16'h4444;
        mem[16'h3005] = 16'h1234;
        mem[16'h3006] = 16'h6666;
        mem[16'h3007] = 16'hAAAA;
        mem[16'h4000] = 16'hBEEF;
        mem[16'h4001] = 16'h7777;
        mem[16'hFFFF] = 16'h1111;
        mem[16'h3010] = 16'h2468;
        test_reset();
        test_fetch();
        test_pause();
        test_redirect();
        test_irq();
        test_wrap();
        test_stall();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
